mbus_timer: RTL and testbench

- Memory-mapped timer/PWM peripheral on the CPU memory bus, directly downstream of the CPU core.
- Decodes the core's address, write-enable and write-data lines, and returns combinational read data on the core's data-in lines.
- Provides a prescaled down-counter with auto-reload, a sticky overflow flag, an interrupt request and a compare-based PWM output.
- Its read data is zero when the block is not selected, so it can be OR-combined with other bus slaves.

---
 rtl/mbus_timer_pkg.sv | 38 +++
 rtl/mbus_slave_if.sv | 35 +++
 rtl/mbus_timer.sv | 110 +++++++++++
 tb/tb_mbus_timer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbus_timer_pkg.sv
// Shared definitions for the memory-bus timer/PWM peripheral: register offsets,
// CTRL bit positions, FSM state encoding and the CTRL register layout.
package mbus_timer_pkg;

    localparam int TMR_CTRL   = 0;
    localparam int TMR_RELOAD = 1;
    localparam int TMR_COUNT  = 2;
    localparam int TMR_STAT   = 3;
    localparam int TMR_CMP    = 4;
    localparam int TMR_NREGS  = 5;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ARL     = 1;
    localparam int CTRL_IEN     = 2;
    localparam int CTRL_PRE_LSB = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic [7:0] pre;
        logic       ien;
        logic       arl;
        logic       en;
    } tmr_ctrl_t;

    // Bus view of CTRL: unused bits read back as zero.
    function automatic logic [15:0] ctrl_to_word(input tmr_ctrl_t c);
        logic [15:0] w;
        w = '0;
        w[CTRL_PRE_LSB +: 8] = c.pre;
        w[CTRL_IEN]          = c.ien;
        w[CTRL_ARL]          = c.arl;
        w[CTRL_EN]           = c.en;
        return w;
    endfunction

endpackage

// File: rtl/mbus_slave_if.sv
// Generic memory-bus slave front end: block select, per-register write strobes
// and a read mux that returns zero when the block is not addressed.
module mbus_slave_if #(
    parameter int                   WIDTH     = 32,
    parameter int                   ADDR_SIZE = 32,
    parameter logic [ADDR_SIZE-1:0] BASE      = '0,
    parameter int                   NREGS     = 5
) (
    input  logic [ADDR_SIZE-1:0]        i_addr,
    input  logic                        i_wen,
    input  logic [NREGS-1:0][WIDTH-1:0] i_rdata,
    output logic                        o_sel,
    output logic [NREGS-1:0]            o_wr,
    output logic [WIDTH-1:0]            o_rdata
);

    logic [3:0] w_off;

    assign o_sel = (i_addr[ADDR_SIZE-1:4] == BASE[ADDR_SIZE-1:4]);
    assign w_off = i_addr[3:0];

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_wr    = '0;
        o_rdata = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (o_sel && (w_off == 4'(i))) begin
                o_wr[i] = i_wen;
                o_rdata = i_rdata[i];
            end
        end
    end

endmodule

// File: rtl/mbus_timer.sv
// Timer/PWM bus slave: prescaled down-counter with optional auto-reload, sticky
// overflow flag, level interrupt and a compare-driven registered PWM output.
module mbus_timer
    import mbus_timer_pkg::*;
#(
    parameter int                   WIDTH     = 32,
    parameter int                   ADDR_SIZE = 32,
    parameter logic [ADDR_SIZE-1:0] BASE      = 32'hFFFF_FF00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] mbus_aout,
    input  logic [WIDTH-1:0]     mbus_dout,
    input  logic                 mbus_wen,
    output logic [WIDTH-1:0]     mbus_din,
    output logic                 irq,
    output logic                 pwm_out,
    output logic                 sel_out
);

    tmr_ctrl_t        r_ctrl;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_cmp;
    logic             r_ovf;
    logic [0:0]       r_state;
    logic [7:0]       r_psc;
    logic             r_pwm;

    logic [TMR_NREGS-1:0]            w_wr;
    logic [TMR_NREGS-1:0][WIDTH-1:0] w_rd;
    logic                            w_tick;

    mbus_slave_if #(
        .WIDTH     (WIDTH),
        .ADDR_SIZE (ADDR_SIZE),
        .BASE      (BASE),
        .NREGS     (TMR_NREGS)
    ) u_slave_if (
        .i_addr  (mbus_aout),
        .i_wen   (mbus_wen),
        .i_rdata (w_rd),
        .o_sel   (sel_out),
        .o_wr    (w_wr),
        .o_rdata (mbus_din)
    );

    always_comb begin
        w_rd                   = '0;
        w_rd[TMR_CTRL][15:0]   = ctrl_to_word(r_ctrl);
        w_rd[TMR_RELOAD]       = r_reload;
        w_rd[TMR_COUNT]        = r_count;
        w_rd[TMR_STAT][1:0]    = {r_state, r_ovf};
        w_rd[TMR_CMP]          = r_cmp;
    end

    assign w_tick  = (r_state == ST_RUN) && (r_psc == r_ctrl.pre);
    assign irq     = r_ovf & r_ctrl.ien;
    assign pwm_out = r_pwm;

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values; later assignments in this block deliberately
    // override earlier ones (overflow beats CTRL, OVF set beats STAT clear).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl   <= '0;
            r_reload <= '0;
            r_count  <= '0;
            r_cmp    <= '0;
            r_ovf    <= 1'b0;
            r_state  <= ST_IDLE;
            r_psc    <= '0;
            r_pwm    <= 1'b0;
        end else begin
            if (w_wr[TMR_CTRL]) begin
                r_ctrl.pre <= mbus_dout[CTRL_PRE_LSB +: 8];
                r_ctrl.ien <= mbus_dout[CTRL_IEN];
                r_ctrl.arl <= mbus_dout[CTRL_ARL];
                r_ctrl.en  <= mbus_dout[CTRL_EN];
                r_state    <= mbus_dout[CTRL_EN] ? ST_RUN : ST_IDLE;
            end
            if (w_wr[TMR_RELOAD]) r_reload <= mbus_dout;
            if (w_wr[TMR_CMP])    r_cmp    <= mbus_dout;
            if (w_wr[TMR_STAT] && mbus_dout[0]) r_ovf <= 1'b0;

            // Prescaler only advances in RUN; a COUNT write restarts it.
            if ((r_state == ST_IDLE) || w_wr[TMR_COUNT] || w_tick) r_psc <= '0;
            else                                                    r_psc <= r_psc + 8'd1;

            if (w_wr[TMR_COUNT]) begin
                r_count <= mbus_dout;
            end else if (w_tick) begin
                if (r_count != '0) begin
                    r_count <= r_count - WIDTH'(1);
                end else begin
                    r_ovf <= 1'b1;
                    if (r_ctrl.arl) begin
                        r_count <= r_reload;
                    end else begin
                        r_ctrl.en <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
            end

            r_pwm <= (r_state == ST_RUN) && (r_count < r_cmp);
        end
    end

endmodule

// File: tb/tb_mbus_timer.sv
// Directed self-checking bench for mbus_timer: reset, one-shot, auto-reload with
// prescaler, PWM duty, write/tick collisions, address decode and mid-count reset.
module tb_mbus_timer;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam logic [31:0] IDLE_ADDR = 32'h0000_0000;
    localparam logic [3:0] OFF_CTRL = 4'd0, OFF_RELOAD = 4'd1, OFF_COUNT = 4'd2,
                           OFF_STAT = 4'd3, OFF_CMP = 4'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mbus_aout;
    logic [31:0] mbus_dout;
    logic        mbus_wen;
    logic [31:0] mbus_din;
    logic        irq;
    logic        pwm_out;
    logic        sel_out;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mbus_timer #(
        .WIDTH     (32),
        .ADDR_SIZE (32),
        .BASE      (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mbus_aout (mbus_aout),
        .mbus_dout (mbus_dout),
        .mbus_wen  (mbus_wen),
        .mbus_din  (mbus_din),
        .irq       (irq),
        .pwm_out   (pwm_out),
        .sel_out   (sel_out)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [31:0] d);
        mbus_aout = BASE | {28'd0, off};
        mbus_dout = d;
        mbus_wen  = 1'b1;
        @(posedge clk);
        #1;
        mbus_wen  = 1'b0;
        mbus_aout = IDLE_ADDR;
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [31:0] d);
        mbus_aout = BASE | {28'd0, off};
        #1;
        d = mbus_din;
        mbus_aout = IDLE_ADDR;
    endtask

    task automatic count_pwm(input int n, output int highs);
        highs = 0;
        repeat (n) begin
            step(1);
            if (pwm_out === 1'b1) highs++;
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset     = 1'b0;
        mbus_wen  = 1'b0;
        mbus_aout = IDLE_ADDR;
        mbus_dout = '0;
        for (int i = 0; i < 3; i++) begin
            mbus_aout = BASE | 32'($urandom_range(0, 15));
            mbus_dout = $urandom;
            mbus_wen  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        mbus_wen = 1'b0;
        for (int off = 0; off < 5; off++) begin
            bus_read(4'(off), d);
            n_total++;
            if (d !== 32'd0) $display("FAIL reset_read off=%0d: got %h expected 0", off, d);
            else n_pass++;
        end
        n_total++;
        if (irq !== 1'b0 || pwm_out !== 1'b0)
            $display("FAIL reset_outputs: irq=%b pwm=%b expected 0 0", irq, pwm_out);
        else n_pass++;
        reset = 1'b1;
        step(1);
        for (int off = 5; off < 16; off++) bus_write(4'(off), 32'hFFFF_FFFF);
        for (int off = 5; off < 16; off++) begin
            bus_read(4'(off), d);
            n_total++;
            if (d !== 32'd0) $display("FAIL unmapped_read off=%0d: got %h expected 0", off, d);
            else n_pass++;
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] d;
        bus_write(OFF_COUNT, 32'd3);
        bus_write(OFF_CTRL, 32'h1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(1);
            bus_read(OFF_COUNT, d);
            n_total++;
            if (d !== 32'(3 - i)) $display("FAIL oneshot_count%0d: got %0d expected %0d", i, d, 3 - i);
            else n_pass++;
        end
        step(1);
        bus_read(OFF_STAT, d);
        n_total++;
        if (d !== 32'h1) $display("FAIL oneshot_stat: got %h expected 1", d);
        else n_pass++;
        bus_read(OFF_CTRL, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL oneshot_ctrl_en: got %h expected 0", d);
        else n_pass++;
        step(3);
        bus_read(OFF_COUNT, d);
        n_total++;
        if (d !== 32'd0) $display("FAIL oneshot_count_hold: got %0d expected 0", d);
        else n_pass++;
        bus_write(OFF_STAT, 32'h1);
        bus_read(OFF_STAT, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL oneshot_stat_clear: got %h expected 0", d);
        else n_pass++;
    endtask

    task automatic test_autoreload;
        logic [31:0] d;
        bus_write(OFF_RELOAD, 32'd4);
        bus_write(OFF_COUNT, 32'd4);
        bus_write(OFF_CTRL, 32'h0207);
        step(14);
        bus_read(OFF_STAT, d);
        n_total++;
        if (d !== 32'h2 || irq !== 1'b0) $display("FAIL arl_before_ovf: stat=%h irq=%b expected 2 0", d, irq);
        else n_pass++;
        step(1);
        bus_read(OFF_STAT, d);
        n_total++;
        if (d !== 32'h3 || irq !== 1'b1) $display("FAIL arl_first_ovf: stat=%h irq=%b expected 3 1", d, irq);
        else n_pass++;
        bus_read(OFF_COUNT, d);
        n_total++;
        if (d !== 32'd4) $display("FAIL arl_reload: got %0d expected 4", d);
        else n_pass++;
        bus_write(OFF_STAT, 32'h1);
        n_total++;
        if (irq !== 1'b0) $display("FAIL arl_irq_clear: got %b expected 0", irq);
        else n_pass++;
        step(13);
        bus_read(OFF_STAT, d);
        n_total++;
        if (d !== 32'h2) $display("FAIL arl_second_before: got %h expected 2", d);
        else n_pass++;
        step(1);
        bus_read(OFF_STAT, d);
        n_total++;
        if (d !== 32'h3 || irq !== 1'b1) $display("FAIL arl_second_ovf: stat=%h irq=%b expected 3 1", d, irq);
        else n_pass++;
        bus_write(OFF_CTRL, 32'h0);
        bus_write(OFF_STAT, 32'h1);
        bus_read(OFF_STAT, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL arl_stop: got %h expected 0", d);
        else n_pass++;
    endtask

    task automatic test_pwm;
        int highs;
        bus_write(OFF_RELOAD, 32'd9);
        bus_write(OFF_CMP, 32'd3);
        bus_write(OFF_COUNT, 32'd9);
        bus_write(OFF_CTRL, 32'h3);
        step(5);
        count_pwm(20, highs);
        n_total++;
        if (highs !== 6) $display("FAIL pwm_duty_3of10: got %0d high cycles expected 6", highs);
        else n_pass++;
        bus_write(OFF_CMP, 32'd0);
        step(2);
        count_pwm(20, highs);
        n_total++;
        if (highs !== 0) $display("FAIL pwm_cmp0: got %0d high cycles expected 0", highs);
        else n_pass++;
        bus_write(OFF_CMP, 32'd20);
        step(2);
        count_pwm(20, highs);
        n_total++;
        if (highs !== 20) $display("FAIL pwm_cmp20: got %0d high cycles expected 20", highs);
        else n_pass++;
        bus_write(OFF_CTRL, 32'h0);
        step(2);
        n_total++;
        if (pwm_out !== 1'b0) $display("FAIL pwm_idle: got %b expected 0", pwm_out);
        else n_pass++;
        bus_write(OFF_STAT, 32'h1);
    endtask

    task automatic test_collisions;
        logic [31:0] d;
        // Overflow lands on the third edge after enable; the STAT clear is committed on it.
        bus_write(OFF_COUNT, 32'd2);
        bus_write(OFF_CTRL, 32'h1);
        step(2);
        bus_write(OFF_STAT, 32'h1);
        bus_read(OFF_STAT, d);
        n_total++;
        if (d !== 32'h1) $display("FAIL collide_stat_ovf: got %h expected 1", d);
        else n_pass++;
        bus_write(OFF_STAT, 32'h1);
        // PRE=3: first tick on the fourth edge after enable, where COUNT is written.
        bus_write(OFF_RELOAD, 32'd50);
        bus_write(OFF_COUNT, 32'd50);
        bus_write(OFF_CTRL, 32'h0303);
        step(3);
        bus_read(OFF_COUNT, d);
        n_total++;
        if (d !== 32'd50) $display("FAIL collide_pre_tick: got %0d expected 50", d);
        else n_pass++;
        bus_write(OFF_COUNT, 32'd100);
        bus_read(OFF_COUNT, d);
        n_total++;
        if (d !== 32'd100) $display("FAIL collide_count_write: got %0d expected 100", d);
        else n_pass++;
        step(3);
        bus_read(OFF_COUNT, d);
        n_total++;
        if (d !== 32'd100) $display("FAIL collide_psc_restart: got %0d expected 100", d);
        else n_pass++;
        step(1);
        bus_read(OFF_COUNT, d);
        n_total++;
        if (d !== 32'd99) $display("FAIL collide_next_tick: got %0d expected 99", d);
        else n_pass++;
        bus_write(OFF_CTRL, 32'h0);
    endtask

    task automatic test_decode;
        logic [31:0] d;
        bus_write(OFF_RELOAD, 32'h0000_1234);
        mbus_aout = (BASE ^ 32'h10) | 32'(OFF_RELOAD);
        mbus_dout = 32'hDEAD_BEEF;
        mbus_wen  = 1'b1;
        #1;
        n_total++;
        if (sel_out !== 1'b0 || mbus_din !== 32'd0)
            $display("FAIL decode_alias_bus: sel=%b din=%h expected 0 0", sel_out, mbus_din);
        else n_pass++;
        @(posedge clk);
        #1;
        mbus_aout = (BASE ^ 32'h10) | 32'(OFF_CTRL);
        mbus_dout = 32'h0000_0007;
        @(posedge clk);
        #1;
        mbus_wen  = 1'b0;
        mbus_aout = IDLE_ADDR;
        bus_read(OFF_RELOAD, d);
        n_total++;
        if (d !== 32'h0000_1234) $display("FAIL decode_reload_kept: got %h expected 1234", d);
        else n_pass++;
        bus_read(OFF_CTRL, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL decode_ctrl_kept: got %h expected 0", d);
        else n_pass++;
        mbus_aout = BASE | 32'(OFF_RELOAD);
        #1;
        n_total++;
        if (sel_out !== 1'b1 || mbus_din !== 32'h0000_1234)
            $display("FAIL decode_selected: sel=%b din=%h expected 1 1234", sel_out, mbus_din);
        else n_pass++;
        mbus_aout = IDLE_ADDR;
    endtask

    task automatic test_midcount_reset;
        logic [31:0] d;
        bus_write(OFF_CMP, 32'd100);
        bus_write(OFF_COUNT, 32'd50);
        bus_write(OFF_CTRL, 32'h0007);
        step(3);
        n_total++;
        if (pwm_out !== 1'b1) $display("FAIL midreset_pwm_before: got %b expected 1", pwm_out);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if (pwm_out !== 1'b0 || irq !== 1'b0) $display("FAIL midreset_outputs: pwm=%b irq=%b expected 0 0", pwm_out, irq);
        else n_pass++;
        bus_read(OFF_COUNT, d);
        n_total++;
        if (d !== 32'd0) $display("FAIL midreset_count: got %0d expected 0", d);
        else n_pass++;
        bus_read(OFF_CTRL, d);
        n_total++;
        if (d !== 32'd0) $display("FAIL midreset_ctrl: got %h expected 0", d);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1);
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_pwm();
        test_collisions();
        test_decode();
        test_midcount_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
